store_forward_buffer: RTL and testbench

Parametrised store buffer with store-to-load forwarding, sitting between the EX/MEM pipeline register and the data memory port. Committed stores are queued instead of writing memory directly, then drained in order whenever the memory port is idle. Loads check the queue and take data from the youngest matching pending store. This generalises the lw→sw forwarding mux to an arbitrary number of in-flight stores and adds a memory-port arbiter.

---
 rtl/store_forward_buffer.sv | 99 +++++++++
 tb/tb_store_forward_buffer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_forward_buffer.sv
// Store buffer between EX/MEM and the data memory port: queues committed stores,
// drains them in order when the port is idle, and forwards the youngest match to loads.
module store_forward_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  output logic                     st_ready,
  output logic                     stall,
  input  logic                     ld_valid,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic                     ld_hit,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ack,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];
  logic [DEPTH-1:0]  ent_valid;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  lookup_idx;
  logic              push;
  logic              pop;

  // Acceptance looks only at registered occupancy, so a full buffer refuses a
  // store even when the head is being drained in the same cycle.
  assign st_ready  = (count < CNT_W'(DEPTH));
  assign stall     = st_valid & ~st_ready;
  assign empty     = (count == '0);
  assign mem_we    = ~empty & ~ld_valid;
  assign mem_addr  = empty ? '0 : ent_addr[rd_ptr];
  assign mem_wdata = empty ? '0 : ent_data[rd_ptr];
  assign push      = st_valid & st_ready;
  assign pop       = mem_we & mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (push) begin
        ent_valid[wr_ptr] <= 1'b1;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        ent_valid[rd_ptr] <= 1'b0;
        rd_ptr            <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload array has no reset; ent_valid and the empty gating on the
  // outputs guarantee stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= st_addr;
      ent_data[wr_ptr] <= st_data;
    end
  end

  // Scan oldest to youngest so the last match (closest to wr_ptr) wins.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    ld_hit     = 1'b0;
    ld_data    = '0;
    lookup_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lookup_idx = rd_ptr + PTR_W'(i);
      if (ent_valid[lookup_idx] &&
          (ent_addr[lookup_idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = ent_data[lookup_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_forward_buffer.sv
// Directed self-checking bench for store_forward_buffer (DEPTH=4, 32-bit),
// with a monitor logging every accepted memory write for in-order comparison.
module tb_store_forward_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        stall;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];

  store_forward_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready), .stall(stall),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && mem_we && mem_ack) got_q.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string tag);
    check({tag, " write count"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s write %0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
    tick();
    st_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    #3;
    check("rst count",    64'(count), 64'd0);
    check("rst empty",    64'(empty), 64'd1);
    check("rst st_ready", 64'(st_ready), 64'd1);
    check("rst stall",    64'(stall), 64'd0);
    check("rst mem_we",   64'(mem_we), 64'd0);
    check("rst mem_addr", 64'(mem_addr), 64'd0);
    check("rst mem_wdata",64'(mem_wdata), 64'd0);
    check("rst ld_hit",   64'(ld_hit), 64'd0);
    check("rst ld_data",  64'(ld_data), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single store drain
    mem_ack = 1'b1;
    st_valid = 1'b1; st_addr = 32'h100; st_data = 32'hDEADBEEF;
    #1;
    check("single st_ready", 64'(st_ready), 64'd1);
    check("single mem_we before push", 64'(mem_we), 64'd0);
    tick();
    st_valid = 1'b0;
    #1;
    check("single mem_we",    64'(mem_we), 64'd1);
    check("single mem_addr",  64'(mem_addr), 64'h100);
    check("single mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    check("single count",     64'(count), 64'd1);
    exp_q.push_back({32'h100, 32'hDEADBEEF});
    tick();
    check("single empty after",    64'(empty), 64'd1);
    check("single mem_addr after", 64'(mem_addr), 64'd0);
    check_log("single");

    // Youngest-match forwarding
    mem_ack = 1'b0;
    push_store(32'h40, 32'h1);
    push_store(32'h80, 32'h2);
    push_store(32'h42, 32'h3);
    ld_valid = 1'b1; ld_addr = 32'h40;
    #1;
    check("fwd hit 0x40",   64'(ld_hit), 64'd1);
    check("fwd data 0x40",  64'(ld_data), 64'h3);
    check("fwd mem_we off", 64'(mem_we), 64'd0);
    ld_addr = 32'h84;
    #1;
    check("fwd hit 0x84",  64'(ld_hit), 64'd0);
    check("fwd data 0x84", 64'(ld_data), 64'd0);
    ld_addr = 32'h83;
    #1;
    check("fwd hit 0x83",  64'(ld_hit), 64'd1);
    check("fwd data 0x83", 64'(ld_data), 64'h2);
    ld_valid = 1'b0;
    mem_ack  = 1'b1;
    exp_q.push_back({32'h40, 32'h1});
    exp_q.push_back({32'h80, 32'h2});
    exp_q.push_back({32'h42, 32'h3});
    tick(); tick(); tick();
    check("fwd drained empty", 64'(empty), 64'd1);
    check_log("fwd");

    // Full buffer backpressure
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_store(32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
      exp_q.push_back({32'h200 + 32'(4 * i), 32'hA0 + 32'(i)});
    end
    st_valid = 1'b1; st_addr = 32'h210; st_data = 32'hA4;
    #1;
    check("full st_ready", 64'(st_ready), 64'd0);
    check("full stall",    64'(stall), 64'd1);
    check("full count",    64'(count), 64'd4);
    mem_ack = 1'b1;
    #1;
    check("full st_ready with ack", 64'(st_ready), 64'd0);
    tick();
    mem_ack = 1'b0;
    check("after pop count",    64'(count), 64'd3);
    check("after pop st_ready", 64'(st_ready), 64'd1);
    check("after pop stall",    64'(stall), 64'd0);
    tick();
    st_valid = 1'b0;
    exp_q.push_back({32'h210, 32'hA4});
    check("5th accepted count", 64'(count), 64'd4);
    check("5th head addr",      64'(mem_addr), 64'h204);
    ld_addr = 32'h210;
    #1;
    check("5th lookup data", 64'(ld_data), 64'hA4);
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("full drained empty", 64'(empty), 64'd1);
    check_log("full");

    // Streaming with simultaneous push/pop and pointer wrap
    mem_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1; st_addr = 32'h300 + 32'(4 * i); st_data = 32'h1000 + 32'(i);
      exp_q.push_back({st_addr, st_data});
      #1;
      check($sformatf("stream stall %0d", i), 64'(stall), 64'd0);
      tick();
      check($sformatf("stream count %0d", i), 64'(count), 64'd1);
    end
    st_valid = 1'b0;
    tick();
    check("stream empty", 64'(empty), 64'd1);
    check_log("stream");

    // Load priority holds the head entry
    mem_ack = 1'b0;
    push_store(32'h400, 32'h11);
    push_store(32'h500, 32'h22);
    ld_valid = 1'b1; ld_addr = 32'h999; mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("ldpri mem_we %0d", i), 64'(mem_we), 64'd0);
      check($sformatf("ldpri count %0d", i), 64'(count), 64'd2);
      tick();
    end
    ld_valid = 1'b0; mem_ack = 1'b0;
    #1;
    check("ldpri mem_we resumes", 64'(mem_we), 64'd1);
    check("ldpri mem_addr held",  64'(mem_addr), 64'h400);
    tick();
    check("ldpri no-ack addr",  64'(mem_addr), 64'h400);
    check("ldpri no-ack wdata", 64'(mem_wdata), 64'h11);
    mem_ack = 1'b1;
    exp_q.push_back({32'h400, 32'h11});
    exp_q.push_back({32'h500, 32'h22});
    tick(); tick();
    check_log("ldpri");

    // Reset mid-stream discards pending stores
    mem_ack = 1'b0;
    push_store(32'h600, 32'h61);
    push_store(32'h604, 32'h62);
    push_store(32'h608, 32'h63);
    check("prereset count", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    check("midrst count",    64'(count), 64'd0);
    check("midrst mem_we",   64'(mem_we), 64'd0);
    check("midrst st_ready", 64'(st_ready), 64'd1);
    ld_addr = 32'h604;
    #1;
    check("midrst ld_hit", 64'(ld_hit), 64'd0);
    mem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    check("postrst mem_we", 64'(mem_we), 64'd0);
    check("postrst empty",  64'(empty), 64'd1);
    check_log("postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
